// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative operand comparator: mode codes,
// FSM states and the mode-dependent decode helpers.
package cmp_pkg;

    typedef enum logic [3:0] {
        MODE_EQ  = 4'd0,
        MODE_NE  = 4'd1,
        MODE_LTS = 4'd2,
        MODE_LTU = 4'd3,
        MODE_GES = 4'd4,
        MODE_GEU = 4'd5,
        MODE_LEZ = 4'd6,
        MODE_GTZ = 4'd7,
        MODE_LTZ = 4'd8,
        MODE_GEZ = 4'd9
    } cmp_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cmp_state_e;

    function automatic logic is_zero_mode(input logic [3:0] m);
        case (m)
            MODE_LEZ, MODE_GTZ, MODE_LTZ, MODE_GEZ: is_zero_mode = 1'b1;
            default:                                is_zero_mode = 1'b0;
        endcase
    endfunction

    // Zero modes always compare signed.
    function automatic logic is_signed(input logic [3:0] m);
        case (m)
            MODE_LTS, MODE_GES, MODE_LEZ, MODE_GTZ, MODE_LTZ, MODE_GEZ: is_signed = 1'b1;
            default:                                                    is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic decode_result(input logic [3:0] m, input logic eq, input logic lt);
        case (m)
            MODE_EQ:                      decode_result = eq;
            MODE_NE:                      decode_result = ~eq;
            MODE_LTS, MODE_LTU, MODE_LTZ: decode_result = lt;
            MODE_GES, MODE_GEU, MODE_GEZ: decode_result = ~lt;
            MODE_LEZ:                     decode_result = lt | eq;
            MODE_GTZ:                     decode_result = ~(lt | eq);
            default:                      decode_result = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned equality / less-than of one operand chunk.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             eq,
    output logic             lt
);

    assign eq = (x == y);
    assign lt = (x < y);

endmodule

// File: rtl/iter_cmp.sv
// Multi-cycle branch comparator: walks the operands CHUNK bits per cycle
// from the MSB down and stops at the first differing chunk.
module iter_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    cmp_state_e       state_r, state_s;
    logic [IDXW-1:0]  idx_r, idx_s;
    logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
    logic [3:0]       mode_r, mode_s;
    logic             done_r, done_s, result_r, result_s;
    logic             eq_r, eq_s, lt_r, lt_s;
    logic [WIDTH-1:0] a_t_s, b_t_s;
    logic [CHUNK-1:0] ch_a_s, ch_b_s;
    logic             ch_eq_s, ch_lt_s;

    // Operand transform applied at latch time: zero modes replace B, and
    // flipping the sign bits turns a signed compare into an unsigned one.
    always_comb begin
        a_t_s = a;
        b_t_s = b;
        if (is_zero_mode(mode)) begin
            b_t_s = {WIDTH{1'b0}};
        end else begin
            b_t_s = b;
        end
        if (is_signed(mode)) begin
            a_t_s = a ^ SIGN_MASK;
            b_t_s = b_t_s ^ SIGN_MASK;
        end else begin
            a_t_s = a;
        end
    end

    assign ch_a_s = a_r[idx_r*CHUNK +: CHUNK];
    assign ch_b_s = b_r[idx_r*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (ch_a_s),
        .y  (ch_b_s),
        .eq (ch_eq_s),
        .lt (ch_lt_s)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        a_s      = a_r;
        b_s      = b_r;
        mode_s   = mode_r;
        done_s   = 1'b0;
        result_s = result_r;
        eq_s     = eq_r;
        lt_s     = lt_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    a_s     = a_t_s;
                    b_s     = b_t_s;
                    mode_s  = mode;
                    idx_s   = IDX_LAST;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (!ch_eq_s) begin
                    eq_s     = 1'b0;
                    lt_s     = ch_lt_s;
                    result_s = decode_result(mode_r, 1'b0, ch_lt_s);
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else if (idx_r == {IDXW{1'b0}}) begin
                    eq_s     = 1'b1;
                    lt_s     = 1'b0;
                    result_s = decode_result(mode_r, 1'b1, 1'b0);
                    done_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    idx_s = idx_r - {{(IDXW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IDXW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            mode_r   <= 4'd0;
            done_r   <= 1'b0;
            result_r <= 1'b0;
            eq_r     <= 1'b0;
            lt_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            a_r      <= a_s;
            b_r      <= b_s;
            mode_r   <= mode_s;
            done_r   <= done_s;
            result_r <= result_s;
            eq_r     <= eq_s;
            lt_r     <= lt_s;
        end
    end

    assign busy   = (state_r == ST_RUN);
    assign done   = done_r;
    assign result = result_r;
    assign eq     = eq_r;
    assign lt     = lt_r;

endmodule

// File: tb/tb_iter_cmp.sv
// Directed self-checking bench for iter_cmp (WIDTH=32, CHUNK=8).
module tb_iter_cmp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, result, eq, lt;

    int n_cmp = 0;
    int n_bad = 0;

    iter_cmp #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .mode(mode),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    // Issue one compare; returns cycles from start edge to done and busy-cycle count.
    task automatic do_cmp(input logic [3:0] m, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int bcyc);
        mode = m; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcyc = 0;
        while (!done && lat < 20) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, eq, lt} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_state: got %b want %b", {busy, done, result, eq, lt}, 5'b00000);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_eq_full;
        int lat, bc;
        do_cmp(4'd0, 32'h12345678, 32'h12345678, lat, bc);
        n_cmp++;
        if (lat !== 5 || bc !== 4) begin
            n_bad++; $display("FAIL eq_latency: got lat=%0d busy=%0d want lat=5 busy=4", lat, bc);
        end
        n_cmp++;
        if ({busy, result, eq, lt} !== 4'b0110) begin
            n_bad++; $display("FAIL eq_result: got %b want %b", {busy, result, eq, lt}, 4'b0110);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL eq_done_width: got %b want 0", done);
        end
    endtask

    task automatic test_early_exit;
        int lat, bc;
        do_cmp(4'd3, 32'h01000000, 32'h02000000, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b101) begin
            n_bad++; $display("FAIL ltu_top: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=101", lat, {result, eq, lt});
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        do_cmp(4'd2, 32'hFFFFFFFF, 32'h00000001, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b101) begin
            n_bad++; $display("FAIL lts_neg: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=101", lat, {result, eq, lt});
        end
        // Started in the done cycle: must be accepted with no bubble.
        do_cmp(4'd3, 32'hFFFFFFFF, 32'h00000001, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b000) begin
            n_bad++; $display("FAIL ltu_b2b: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=000", lat, {result, eq, lt});
        end
    endtask

    task automatic test_zero_modes;
        int lat, bc;
        do_cmp(4'd7, 32'h00000000, 32'hDEADBEEF, lat, bc);
        n_cmp++;
        if (lat !== 5 || {result, eq, lt} !== 3'b010) begin
            n_bad++; $display("FAIL gtz_zero: got lat=%0d r/eq/lt=%b want lat=5 r/eq/lt=010", lat, {result, eq, lt});
        end
        do_cmp(4'd9, 32'h7FFFFFFF, 32'h00000005, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b100) begin
            n_bad++; $display("FAIL gez_pos: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=100", lat, {result, eq, lt});
        end
        do_cmp(4'd6, 32'h80000000, 32'h12345678, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b101) begin
            n_bad++; $display("FAIL lez_min: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=101", lat, {result, eq, lt});
        end
    endtask

    task automatic test_misc_modes;
        int lat, bc;
        do_cmp(4'd1, 32'h00000001, 32'h00000002, lat, bc);
        n_cmp++;
        if (lat !== 5 || {result, eq, lt} !== 3'b101) begin
            n_bad++; $display("FAIL ne_low: got lat=%0d r/eq/lt=%b want lat=5 r/eq/lt=101", lat, {result, eq, lt});
        end
        // Reserved code: unsigned compare, result forced low.
        do_cmp(4'd10, 32'h00000001, 32'h80000000, lat, bc);
        n_cmp++;
        if (lat !== 2 || {result, eq, lt} !== 3'b001) begin
            n_bad++; $display("FAIL rsvd_mode: got lat=%0d r/eq/lt=%b want lat=2 r/eq/lt=001", lat, {result, eq, lt});
        end
    endtask

    task automatic test_flush;
        int dcnt;
        // Outputs before flush are from the reserved-mode compare: r/eq/lt = 001.
        mode = 4'd0; a = 32'hAAAA5555; b = 32'hAAAA5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        n_cmp++;
        if ({busy, done, result, eq, lt} !== 5'b00001) begin
            n_bad++; $display("FAIL flush_abort: got %b want %b", {busy, done, result, eq, lt}, 5'b00001);
        end
        dcnt = 0;
        repeat (6) begin @(posedge clk); #1; if (done) dcnt++; end
        n_cmp++;
        if (dcnt !== 0) begin
            n_bad++; $display("FAIL flush_no_done: got %0d dones want 0", dcnt);
        end
        // Start pulsed while busy with different data must be ignored.
        mode = 4'd0; a = 32'h0000AAAA; b = 32'h0000AAAA; start = 1'b1;
        @(posedge clk); #1;
        a = 32'h0000AAAB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcnt = 0;
        repeat (10) begin if (done) dcnt++; @(posedge clk); #1; end
        n_cmp++;
        if (dcnt !== 1 || {result, eq, lt} !== 3'b110) begin
            n_bad++; $display("FAIL start_busy: got dones=%0d r/eq/lt=%b want dones=1 r/eq/lt=110", dcnt, {result, eq, lt});
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, dcnt;
        mode = 4'd0; a = 32'h55555555; b = 32'h55555555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_cmp++;
        if ({busy, done, result, eq, lt} !== 5'b00000) begin
            n_bad++; $display("FAIL reset_mid_run: got %b want %b", {busy, done, result, eq, lt}, 5'b00000);
        end
        dcnt = 0;
        repeat (6) begin @(posedge clk); #1; if (done) dcnt++; end
        n_cmp++;
        if (dcnt !== 0) begin
            n_bad++; $display("FAIL reset_no_done: got %0d dones want 0", dcnt);
        end
        do_cmp(4'd5, 32'h00000005, 32'h00000003, lat, bc);
        n_cmp++;
        if (lat !== 5 || bc !== 4 || {result, eq, lt} !== 3'b100) begin
            n_bad++; $display("FAIL after_reset: got lat=%0d busy=%0d r/eq/lt=%b want lat=5 busy=4 r/eq/lt=100", lat, bc, {result, eq, lt});
        end
    endtask

    initial begin
        test_reset();
        test_eq_full();
        test_early_exit();
        test_back_to_back();
        test_zero_modes();
        test_misc_modes();
        test_flush();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iter_cmp.md
# iter_cmp

Multi-cycle, parametrised operand comparator for the next-generation branch unit of the pipelined CPU. It replaces the single-cycle 32-bit equality check with a set of compare modes:
- equal and not-equal;
- signed and unsigned magnitude;
- compare-against-zero.

Operands are compared CHUNK bits per cycle from MSB to LSB, with early exit as soon as the outcome is decided. A start/busy/done handshake lets the decode stage stall on it, and a flush aborts an in-flight compare when the branch is squashed.

## Interface
- WIDTH, 32: operand width; WIDTH >= 2, WIDTH % CHUNK == 0
- CHUNK, 8: bits examined per RUN cycle; 1 <= CHUNK <= WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- start  in  1  request; sampled only in IDLE
- flush  in  1  abort current compare
- mode  in  4  compare mode, cmp_pkg encoding
- a  in  WIDTH  operand A (sampled on accepted start)
- b  in  WIDTH  operand B (sampled on accepted start; ignored in zero modes)
- busy  out  1  1 while in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  1  mode outcome (branch taken)
- eq  out  1  A == B' (B' = B, or 0 in zero modes)
- lt  out  1  A < B', signed or unsigned per mode

## Operation
- **Modes:** EQ=0, NE=1, LTS=2, LTU=3, GES=4, GEU=5, LEZ=6, GTZ=7, LTZ=8, GEZ=9. Codes 10-15 give result=0 with eq/lt computed as unsigned.
- **Zero modes** (LEZ, GTZ, LTZ, GEZ): B' = 0, compare is signed.
- **Signed compare:** XOR bit WIDTH-1 of both operands at latch time, then compare unsigned.
- **result:**
  - EQ: eq
  - NE: !eq
  - LTS/LTU/LTZ: lt
  - GES/GEU/GEZ: !lt
  - LEZ: lt|eq
  - GTZ: !(lt|eq)
- **FSM IDLE:**
  - start=1 and flush=0: latch the transformed A and B', latch mode, set idx = NCHUNK-1 (NCHUNK = WIDTH/CHUNK), go to RUN.
  - Otherwise stay in IDLE.
- **FSM RUN:** compare chunk idx combinationally.
  - Chunks differ: at the next edge register eq=0, lt=(A chunk < B chunk), result; done=1; go to IDLE.
  - Chunks equal and idx==0: register eq=1, lt=0, result; done=1; go to IDLE.
  - Otherwise: idx-1, stay in RUN.
- **flush:** has priority over everything except reset. In RUN, go to IDLE at the next edge with no done pulse; eq/lt/result keep their previous values. In IDLE, a start in the same cycle is dropped.
- **start while busy:** ignored, not queued. The requester holds start until it sees done.
- **Outputs between compares:** eq/lt/result hold their last values until the next completion.

## Timing
- **Reset values:** state IDLE, busy=0, done=0, result=0, eq=0, lt=0, idx=0.
- **Latency:** start sampled at edge t, RUN begins in cycle t+1, decided after k chunks, done high in the cycle after edge t+k.
  - Minimum 2 cycles from start to done (k=1).
  - Maximum NCHUNK+1 cycles.
- **done:** high exactly one cycle, with state already IDLE. A start in the done cycle is accepted, so back-to-back compares have zero bubble.
- **busy:** high from the cycle after an accepted start up to and including the last RUN cycle.
- **Reset mid-RUN:** all outputs return to reset values at the next edge and no done is issued.
- **CHUNK == WIDTH:** every compare takes exactly 2 cycles.

## Structure
- **cmp_pkg:** mode enum constants (4-bit), the is_signed(mode) and is_zero_mode(mode) functions, and the result-decode function of (mode, eq, lt).
- **cmp_chunk:** combinational sub-module taking two CHUNK-bit inputs and producing eq and lt. It is instantiated once and fed by an idx-selected slice.
- **iter_cmp:** contains the FSM, idx counter, operand registers and output registers.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- EQ, a=b=0x12345678 -> busy 4 cycles; done 5 cycles after start; result=1, eq=1, lt=0.
- LTU, a=0x01000000, b=0x02000000 -> decided on top chunk; done 2 cycles after start; result=1, lt=1.
- LTS, a=0xFFFFFFFF, b=0x00000001 -> result=1. Repeat with LTU -> result=0. Second start issued in the done cycle is accepted.
- GTZ, a=0 -> 4 chunks, result=0, eq=1. Then LEZ, a=0x80000000 -> done after 1 chunk, result=1.
- **Flush:** EQ with a=b, flush in the 2nd RUN cycle -> busy=0 next cycle, no done, result/eq unchanged. A start while busy produces no extra done.
- **Reset:** reset=0 in a RUN cycle -> next cycle busy=0, done=0, result=eq=lt=0; a later start works normally.
